// File: rtl/dac_playout_ctrl_pkg.sv
// dac_pkg: shared definitions for the DAC playout sequencer.
//   DATA_W     sample width (offset binary)
//   MIDSCALE   idle/quiet output code
//   state_t    FSM encodings, also exported on the debug state port
//   ch_mode_t  channel mapping: mirror (A=B) or interleave (even->A, odd->B)
package dac_pkg;

  localparam int DATA_W = 14;
  localparam logic [DATA_W-1:0] MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_UNDER = 2'd3
  } state_t;

  typedef enum logic {
    CH_MIRROR     = 1'b0,
    CH_INTERLEAVE = 1'b1
  } ch_mode_t;

endpackage

// File: rtl/dac_playout_ctrl_if.sv
// dac_playout_ctrl_if: control, FIFO read port and DAC output bundle.
//   enable, ch_mode                 run control and channel mapping
//   fifo_count/full/empty, rd_data  FIFO read-side status and data
//   rd_en                           FIFO pop strobe (data valid one clk later)
//   dac_dataA_out/B_out, sample_stb registered DAC samples and update pulse
//   underrun, state                 sticky underrun flag and FSM debug state
// Modports:
//   master  the playout sequencer (issues pops, drives the DACs)
//   slave   the surrounding FIFO/host side
interface dac_playout_ctrl_if #(
  parameter int CNT_W = 6
) ();
  import dac_pkg::*;

  logic              enable;
  logic              ch_mode;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dac_dataA_out;
  logic [DATA_W-1:0] dac_dataB_out;
  logic              sample_stb;
  logic              underrun;
  logic [1:0]        state;

  modport master (
    input  enable, ch_mode, fifo_count, fifo_full, fifo_empty, rd_data,
    output rd_en, dac_dataA_out, dac_dataB_out, sample_stb, underrun, state
  );

  modport slave (
    output enable, ch_mode, fifo_count, fifo_full, fifo_empty, rd_data,
    input  rd_en, dac_dataA_out, dac_dataB_out, sample_stb, underrun, state
  );

endinterface

// File: rtl/dac_playout_ctrl_phase_timer.sv
// dac_phase_timer: free-running US_PARAM-bit phase counter for the output
// period (2^US_PARAM clocks). Wraps naturally at 2^US_PARAM-1 -> 0.
//   clk, rst  clock and asynchronous active-high reset
//   clear     forces phase to 0 on the next edge (held outside RUN)
//   tick      phase == 0, start of an output period
//   tick1     phase == 1, slot of the second interleave pop
module dac_phase_timer #(
  parameter int US_PARAM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tick1
);

  logic [US_PARAM-1:0] phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else begin
      phase <= phase + US_PARAM'(1);
    end
  end

  assign tick  = (phase == '0);
  assign tick1 = (phase == US_PARAM'(1));

endmodule

// File: rtl/dac_playout_ctrl.sv
// dac_playout_ctrl: read-side sequencer between the sample FIFO and the
// dual DAC output registers. Primes the FIFO to START_LVL, then pops one
// sample (mirror) or a pair (interleave) per 2^US_PARAM clocks. On a
// starved tick it flags a sticky underrun, holds the outputs and re-primes.
//   clk, rst  clock and asynchronous active-high reset
//   bus       dac_playout_ctrl_if.master (control, FIFO port, DAC outputs)
module dac_playout_ctrl
  import dac_pkg::*;
#(
  parameter int CNT_W     = 6,
  parameter int US_PARAM  = 4,
  parameter int START_LVL = 16
) (
  input  logic              clk,
  input  logic              rst,
  dac_playout_ctrl_if.master bus
);

  state_t            state_q;
  ch_mode_t          mode_q;         // ch_mode captured at the last popping tick
  logic              pend_first_q;   // rd_data this clk is the first word of the period
  logic              pend_second_q;  // rd_data this clk is the interleave B word
  logic [DATA_W-1:0] slot_a_q;       // interleave A word waiting for its partner
  logic [DATA_W-1:0] dac_a_q;
  logic [DATA_W-1:0] dac_b_q;
  logic              stb_q;
  logic              underrun_q;

  logic tick;
  logic tick1;
  logic in_run;
  logic level_ok;
  logic pair_ok;
  logic first_pop;
  logic second_pop;

  // fifo_count wraps to 0 when full, so the full flag always qualifies.
  assign level_ok = bus.fifo_full ||
                    ({1'b0, bus.fifo_count} >= (CNT_W+1)'(START_LVL));
  assign pair_ok  = !bus.fifo_empty &&
                    (bus.fifo_full || (bus.fifo_count >= CNT_W'(2)));

  // Gating on enable here makes a same-cycle disable win over a tick.
  assign in_run = bus.enable && (state_q == ST_RUN);

  dac_phase_timer #(
    .US_PARAM (US_PARAM)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_run),
    .tick  (tick),
    .tick1 (tick1)
  );

  // The pop strobe is decoded from registered state plus this cycle's FIFO
  // flags so it can never fire into an empty FIFO or after enable drops.
  // An interleave pair is committed at the tick, so the second pop only
  // follows a first pop of the same period.
  assign first_pop  = in_run && tick &&
                      ((bus.ch_mode == CH_INTERLEAVE) ? pair_ok : !bus.fifo_empty);
  assign second_pop = in_run && tick1 && pend_first_q &&
                      (mode_q == CH_INTERLEAVE) && !bus.fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= CH_MIRROR;
      pend_first_q  <= 1'b0;
      pend_second_q <= 1'b0;
      slot_a_q      <= MIDSCALE;
      dac_a_q       <= MIDSCALE;
      dac_b_q       <= MIDSCALE;
      stb_q         <= 1'b0;
      underrun_q    <= 1'b0;
    end else if (!bus.enable) begin
      // Any in-flight word is dropped: pending flags clear and the
      // outputs go quiet instead of taking the arriving data.
      state_q       <= ST_IDLE;
      pend_first_q  <= 1'b0;
      pend_second_q <= 1'b0;
      dac_a_q       <= MIDSCALE;
      dac_b_q       <= MIDSCALE;
      stb_q         <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      stb_q         <= 1'b0;
      pend_first_q  <= first_pop;
      pend_second_q <= second_pop;

      // NOTE: the default arm keeps the decode total; in an always_ff that
      // is about recovery from illegal encodings, not latch avoidance.
      case (state_q)
        ST_IDLE:  state_q <= ST_PRIME;
        ST_PRIME: if (level_ok) state_q <= ST_RUN;
        ST_RUN: begin
          if (tick) begin
            if (first_pop) begin
              mode_q <= ch_mode_t'(bus.ch_mode);
            end else begin
              state_q    <= ST_UNDER;
              underrun_q <= 1'b1;
            end
          end
        end
        ST_UNDER: state_q <= ST_PRIME;
        default:  state_q <= ST_IDLE;
      endcase

      // Read pipeline: data returns one clk after each pop.
      if (pend_first_q) begin
        if (mode_q == CH_INTERLEAVE) begin
          slot_a_q <= bus.rd_data;
        end else begin
          dac_a_q <= bus.rd_data;
          dac_b_q <= bus.rd_data;
          stb_q   <= 1'b1;
        end
      end
      if (pend_second_q) begin
        dac_a_q <= slot_a_q;
        dac_b_q <= bus.rd_data;
        stb_q   <= 1'b1;
      end
    end
  end

  assign bus.rd_en         = first_pop || second_pop;
  assign bus.dac_dataA_out = dac_a_q;
  assign bus.dac_dataB_out = dac_b_q;
  assign bus.sample_stb    = stb_q;
  assign bus.underrun      = underrun_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_dac_playout_ctrl.sv
// tb_dac_playout_ctrl: directed bench for dac_playout_ctrl with a 64-deep
// behavioural FIFO (count wraps to 0 when full, data one clk after pop).
// Default parameters: US_PARAM=4 (16-clk period), START_LVL=16.
module tb_dac_playout_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Behavioural FIFO: writes from the stimulus, pops from the DUT.
  logic [13:0] mem [64];
  int          wr_cnt   = 0;
  int          rd_cnt   = 0;
  int          bad_pops = 0;
  int          occ;
  logic        flush_req = 1'b0;
  logic [13:0] rd_data_q = '0;

  dac_playout_ctrl_if #(.CNT_W(6)) bus ();

  dac_playout_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign occ            = wr_cnt - rd_cnt;
  assign bus.fifo_count = occ[5:0];
  assign bus.fifo_full  = (occ == 64);
  assign bus.fifo_empty = (occ == 0);
  assign bus.rd_data    = rd_data_q;

  always @(posedge clk) begin
    if (flush_req) begin
      rd_cnt <= wr_cnt;
    end else if (bus.rd_en) begin
      if (occ == 0) begin
        bad_pops <= bad_pops + 1;
      end else begin
        rd_data_q <= mem[rd_cnt[5:0]];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [13:0] w);
    @(negedge clk);
    mem[wr_cnt[5:0]] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic flush();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  task automatic disable_and_check(input string tag);
    adv(1);
    bus.enable = 1'b0;
    adv(1);
    check({tag, "_state"}, 32'(bus.state), 0);
    check({tag, "_underrun"}, 32'(bus.underrun), 0);
    check({tag, "_a"}, 32'(bus.dac_dataA_out), 32'h2000);
    check({tag, "_b"}, 32'(bus.dac_dataB_out), 32'h2000);
  endtask

  initial begin
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.ch_mode = 1'b0;
    adv(3);
    rst = 1'b0;

    // 1. Reset and idle with enable low
    for (int i = 0; i < 4; i++) begin
      adv(1);
      check("idle_rd_en", 32'(bus.rd_en), 0);
    end
    check("idle_state", 32'(bus.state), 0);
    check("idle_a", 32'(bus.dac_dataA_out), 32'h2000);
    check("idle_b", 32'(bus.dac_dataB_out), 32'h2000);
    check("idle_stb", 32'(bus.sample_stb), 0);
    check("idle_underrun", 32'(bus.underrun), 0);

    // 2. Mirror: enable, fill to the start level, then steady playout
    adv(1);
    bus.enable = 1'b1;
    for (int i = 0; i < 15; i++) push(14'(i));
    adv(1);
    check("prime_state", 32'(bus.state), 1);
    check("prime_rd_en", 32'(bus.rd_en), 0);
    push(14'd15);
    adv(1);
    for (int s = 0; s < 16; s++) begin
      check("mir_rd_en", 32'(bus.rd_en), 1);
      check("mir_state", 32'(bus.state), 2);
      adv(1);
      check("mir_stb_early", 32'(bus.sample_stb), 0);
      adv(1);
      check("mir_a", 32'(bus.dac_dataA_out), 32'(s));
      check("mir_b", 32'(bus.dac_dataB_out), 32'(s));
      check("mir_stb", 32'(bus.sample_stb), 1);
      adv(14);
    end

    // 3. Drained: underrun, hold last sample, re-prime, resume
    check("under_rd_en", 32'(bus.rd_en), 0);
    adv(1);
    check("under_state", 32'(bus.state), 3);
    check("under_flag", 32'(bus.underrun), 1);
    check("under_hold_a", 32'(bus.dac_dataA_out), 15);
    check("under_hold_b", 32'(bus.dac_dataB_out), 15);
    adv(1);
    check("reprime_state", 32'(bus.state), 1);
    check("reprime_hold_a", 32'(bus.dac_dataA_out), 15);
    for (int i = 0; i < 16; i++) push(14'(16 + i));
    adv(1);
    check("resume_state", 32'(bus.state), 2);
    check("resume_rd_en", 32'(bus.rd_en), 1);
    check("resume_sticky", 32'(bus.underrun), 1);
    adv(2);
    check("resume_a", 32'(bus.dac_dataA_out), 16);
    check("resume_stb", 32'(bus.sample_stb), 1);
    check("resume_sticky2", 32'(bus.underrun), 1);
    disable_and_check("dis1");
    flush();

    // 4. Interleave: pairs 0x100/0x101, 0x102/0x103, ...
    bus.ch_mode = 1'b1;
    for (int i = 0; i < 17; i++) push(14'(14'h100 + i));
    adv(1);
    bus.enable = 1'b1;
    adv(1);
    check("il_prime", 32'(bus.state), 1);
    adv(1);
    for (int s = 0; s < 8; s++) begin
      check("il_rd_en_first", 32'(bus.rd_en), 1);
      adv(1);
      check("il_rd_en_second", 32'(bus.rd_en), 1);
      adv(1);
      check("il_rd_en_gap", 32'(bus.rd_en), 0);
      check("il_stb_early", 32'(bus.sample_stb), 0);
      adv(1);
      check("il_a", 32'(bus.dac_dataA_out), 32'h100 + 32'(2 * s));
      check("il_b", 32'(bus.dac_dataB_out), 32'h101 + 32'(2 * s));
      check("il_stb", 32'(bus.sample_stb), 1);
      adv(13);
    end

    // 5. One word left at tick: no lone pop, underrun
    check("il_short_rd_en", 32'(bus.rd_en), 0);
    adv(1);
    check("il_under_state", 32'(bus.state), 3);
    check("il_under_flag", 32'(bus.underrun), 1);
    check("il_word_kept", 32'(bus.fifo_empty), 0);
    check("il_count_kept", 32'(bus.fifo_count), 1);
    check("il_hold_a", 32'(bus.dac_dataA_out), 32'h10E);
    check("il_hold_b", 32'(bus.dac_dataB_out), 32'h10F);
    disable_and_check("dis2");
    flush();

    // 6. Full FIFO (count wraps to 0) exits PRIME; disable discards in-flight word
    bus.ch_mode = 1'b0;
    for (int i = 0; i < 64; i++) push(14'(14'h200 + i));
    adv(1);
    bus.enable = 1'b1;
    adv(2);
    check("full_state", 32'(bus.state), 2);
    check("full_rd_en", 32'(bus.rd_en), 1);
    adv(1);
    bus.enable = 1'b0;
    adv(1);
    check("discard_state", 32'(bus.state), 0);
    check("discard_a", 32'(bus.dac_dataA_out), 32'h2000);
    check("discard_b", 32'(bus.dac_dataB_out), 32'h2000);
    check("discard_stb", 32'(bus.sample_stb), 0);
    for (int i = 0; i < 3; i++) begin
      adv(1);
      check("discard_no_rd_en", 32'(bus.rd_en), 0);
      check("discard_stb_late", 32'(bus.sample_stb), 0);
    end
    check("discard_count", 32'(bus.fifo_count), 63);

    // 7. Tick coinciding with enable=0: no pop
    bus.enable = 1'b1;
    adv(2);
    check("coinc_state", 32'(bus.state), 2);
    check("coinc_rd_en_pre", 32'(bus.rd_en), 1);
    bus.enable = 1'b0;
    #1;
    check("coinc_rd_en", 32'(bus.rd_en), 0);
    adv(1);
    check("coinc_idle", 32'(bus.state), 0);
    check("coinc_count", 32'(bus.fifo_count), 63);

    check("no_pop_when_empty", 32'(bad_pops), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
